// File: rtl/addsub_seq16_pkg.sv
// addsub_seq16_pkg: shared state encoding, slice width and overflow helper
package addsub_seq16_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIBBLE_W = 4;
  function automatic logic ovf(input logic a_msb, input logic b_msb, input logic sub, input logic s_msb);
    return (a_msb ^ s_msb) & ~(a_msb ^ (b_msb ^ sub));
  endfunction
endpackage

// File: rtl/add4b.sv
// add4b: 4-bit carry-lookahead add/sub slice; inv_i complements b
module add4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_i,
  input  logic       inv_i,
  output logic [3:0] s,
  output logic       c_o
);
  logic [3:0] bb, g, p;
  logic [4:0] c;
  assign bb = b ^ {4{inv_i}};
  assign g = a & bb;
  assign p = a ^ bb;
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);
  assign s = p ^ c[3:0];
  assign c_o = c[4];
endmodule

// File: rtl/addsub_seq16.sv
// addsub_seq16: nibble-serial WIDTH-bit add/sub built on one time-multiplexed add4b slice
module addsub_seq16
  import addsub_seq16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             v_o,
  output logic             z_o,
  output logic             n_o
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);
  state_t state, state_next;
  logic [IDX_W-1:0] idx;
  logic carry, sub_q, slice_c;
  logic [WIDTH-1:0] a_q, b_q, s_next;
  logic [NIBBLE_W-1:0] sum;
  add4b u_slice (
    .a    (a_q[idx*NIBBLE_W +: NIBBLE_W]),
    .b    (b_q[idx*NIBBLE_W +: NIBBLE_W]),
    .c_i  (carry),
    .inv_i(sub_q),
    .s    (sum),
    .c_o  (slice_c)
  );
  always_comb begin
    state_next = state == IDLE ? (start_i ? RUN : IDLE)
               : state == RUN  ? (idx == LAST ? DONE : RUN)
               : IDLE;
    s_next = s_o;
    s_next[idx*NIBBLE_W +: NIBBLE_W] = sum;
  end
  assign ready_o = state == IDLE;
  assign done_o = state == DONE;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      s_o <= '0;
      c_o <= 1'b0;
      v_o <= 1'b0;
      z_o <= 1'b0;
      n_o <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start_i) begin
        a_q <= a_i;
        b_q <= b_i;
        sub_q <= sub_i;
        carry <= sub_i;
        idx <= '0;
      end
      if (state == RUN) begin
        s_o <= s_next;
        carry <= slice_c;
        idx <= idx == LAST ? '0 : idx + 1'b1;
        if (idx == LAST) begin
          c_o <= slice_c;
          n_o <= s_next[WIDTH-1];
          z_o <= s_next == '0;
          v_o <= ovf(a_q[WIDTH-1], b_q[WIDTH-1], sub_q, s_next[WIDTH-1]);
        end
      end
    end
  end
endmodule
